// File: rtl/axis_fft_pkg.sv
// Shared types and config-word helpers for the xfft framing front-end.
package axis_fft_pkg;

  typedef enum logic [1:0] {CFG, STREAM, PAD} state_t;

  localparam int CFG_LOG2N_LSB = 0;
  localparam int CFG_LOG2N_W   = 4;
  localparam int CFG_FWD_BIT   = 8;
  localparam int CFG_SCALE_LSB = 9;
  localparam int CFG_SCALE_W   = 12;
  localparam int CFG_BASE_W    = 24;

  function automatic logic [CFG_SCALE_W-1:0] scale_sch(input logic [3:0] log2n);
    case (log2n)
      4'd0, 4'd1, 4'd2, 4'd3: return 12'd6;
      4'd4:  return 12'd10;
      4'd5:  return 12'd26;
      4'd6:  return 12'd42;
      4'd7:  return 12'd106;
      4'd8:  return 12'd170;
      4'd9:  return 12'd426;
      4'd10: return 12'd682;
      4'd11: return 12'd1706;
      default: return 12'd2730;
    endcase
  endfunction

  function automatic logic [CFG_BASE_W-1:0] build_cfg(input logic [3:0] log2n, input logic fwd);
    logic [CFG_BASE_W-1:0] w;
    w = '0;
    w[CFG_LOG2N_LSB +: CFG_LOG2N_W] = log2n;
    w[CFG_FWD_BIT]                  = fwd;
    w[CFG_SCALE_LSB +: CFG_SCALE_W] = scale_sch(log2n);
    return w;
  endfunction

endpackage

// File: rtl/axis_fft_frame_ctrl_cfg_gen.sv
// Pending size/direction register with clamping, plus the latched in-flight config word.
module axis_fft_cfg_gen
  import axis_fft_pkg::*;
#(
  parameter int MIN_LOG2N = 3,
  parameter int MAX_LOG2N = 12,
  parameter int CFG_W     = 24
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [3:0]       cfg_log2n,
  input  logic             cfg_fwd,
  input  logic             cfg_update,
  input  logic             load,
  output logic [3:0]       pend_log2n_nx,
  output logic             pend_fwd_nx,
  output logic [3:0]       word_log2n,
  output logic             word_fwd,
  output logic [CFG_W-1:0] cfg_word
);

  logic [3:0] pend_log2n;
  logic       pend_fwd;

  function automatic logic [3:0] clamp(input logic [3:0] v);
    if (int'(v) < MIN_LOG2N) return 4'(MIN_LOG2N);
    if (int'(v) > MAX_LOG2N) return 4'(MAX_LOG2N);
    return v;
  endfunction

  // A pulse coincident with a frame boundary must be visible to that boundary.
  assign pend_log2n_nx = cfg_update ? clamp(cfg_log2n) : pend_log2n;
  assign pend_fwd_nx   = cfg_update ? cfg_fwd : pend_fwd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      pend_log2n <= clamp(cfg_log2n);
      pend_fwd   <= cfg_fwd;
      word_log2n <= clamp(cfg_log2n);
      word_fwd   <= cfg_fwd;
    end else begin
      pend_log2n <= pend_log2n_nx;
      pend_fwd   <= pend_fwd_nx;
      if (load) begin
        word_log2n <= pend_log2n_nx;
        word_fwd   <= pend_fwd_nx;
      end
    end
  end

  assign cfg_word = CFG_W'(build_cfg(word_log2n, word_fwd));

endmodule

// File: rtl/axis_fft_frame_ctrl.sv
// Frames a sample stream for xfft and issues config words at size changes.
// Optional zero-padding flush: define AXIS_FFT_FRAME_ZERO_PAD_EN.
module axis_fft_frame_ctrl
  import axis_fft_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MIN_LOG2N = 3,
  parameter int MAX_LOG2N = 12,
  parameter int CFG_W     = 24
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [3:0]        cfg_log2n,
  input  logic              cfg_fwd,
  input  logic              cfg_update,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_flush,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              m_axis_data_tlast,
  output logic [CFG_W-1:0]  m_axis_config_tdata,
  output logic              m_axis_config_tvalid,
  input  logic              m_axis_config_tready,
  output logic [15:0]       frame_cnt,
  output logic [3:0]        cur_log2n
);

  state_t               state, state_nx;
  logic [MAX_LOG2N-1:0] cnt;
  logic [MAX_LOG2N:0]   last_full;
  logic                 cur_fwd;
  logic                 at_last, hs, load;
  logic [3:0]           pend_log2n_nx, word_log2n;
  logic                 pend_fwd_nx, word_fwd;

  axis_fft_cfg_gen #(
    .MIN_LOG2N(MIN_LOG2N),
    .MAX_LOG2N(MAX_LOG2N),
    .CFG_W    (CFG_W)
  ) u_cfg_gen (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_log2n    (cfg_log2n),
    .cfg_fwd      (cfg_fwd),
    .cfg_update   (cfg_update),
    .load         (load),
    .pend_log2n_nx(pend_log2n_nx),
    .pend_fwd_nx  (pend_fwd_nx),
    .word_log2n   (word_log2n),
    .word_fwd     (word_fwd),
    .cfg_word     (m_axis_config_tdata)
  );

  assign last_full = ((MAX_LOG2N+1)'(1) << cur_log2n) - (MAX_LOG2N+1)'(1);
  assign at_last   = (cnt == last_full[MAX_LOG2N-1:0]);

`ifndef AXIS_FFT_FRAME_ZERO_PAD_EN
  logic unused_flush;
  assign unused_flush = s_flush;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_nx             = state;
    s_axis_tready        = 1'b0;
    m_axis_data_tvalid   = 1'b0;
    m_axis_data_tdata    = s_axis_tdata;
    m_axis_data_tlast    = 1'b0;
    m_axis_config_tvalid = 1'b0;
    hs                   = 1'b0;
    load                 = 1'b0;
    if (!areset) begin
      case (state)
        CFG: begin
          m_axis_config_tvalid = 1'b1;
          if (m_axis_config_tready) state_nx = STREAM;
        end
        STREAM: begin
          m_axis_data_tvalid = s_axis_tvalid;
          s_axis_tready      = m_axis_data_tready;
          m_axis_data_tlast  = at_last;
          hs                 = s_axis_tvalid && m_axis_data_tready;
          if (hs && at_last) begin
            if ({pend_log2n_nx, pend_fwd_nx} != {cur_log2n, cur_fwd}) begin
              state_nx = CFG;
              load     = 1'b1;
            end
`ifdef AXIS_FFT_FRAME_ZERO_PAD_EN
          end else if (s_flush && cnt != '0) begin
            state_nx = PAD;
`endif
          end
        end
`ifdef AXIS_FFT_FRAME_ZERO_PAD_EN
        PAD: begin
          m_axis_data_tvalid = 1'b1;
          m_axis_data_tdata  = '0;
          m_axis_data_tlast  = at_last;
          hs                 = m_axis_data_tready;
          if (hs && at_last) begin
            if ({pend_log2n_nx, pend_fwd_nx} != {cur_log2n, cur_fwd}) begin
              state_nx = CFG;
              load     = 1'b1;
            end else begin
              state_nx = STREAM;
            end
          end
        end
`endif
        default: state_nx = CFG;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= CFG;
      cnt       <= '0;
      frame_cnt <= '0;
      cur_log2n <= 4'(MIN_LOG2N);
      cur_fwd   <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == CFG && m_axis_config_tready) begin
        cur_log2n <= word_log2n;
        cur_fwd   <= word_fwd;
      end
      if (hs) begin
        if (at_last) begin
          cnt       <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          cnt <= cnt + MAX_LOG2N'(1);
        end
      end
    end
  end

endmodule
